// File: rtl/imem_loader.sv
// Boot loader: parses a host byte stream (word count, big-endian words, XOR checksum)
// into instruction-memory writes and releases the CPU reset once the image is verified.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_V = 17'(DEPTH);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [7:0]        cnt_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        byte_cnt;
  logic [7:0]        csum;
  logic [23:0]       shreg;

  logic              accept;
  logic [15:0]       hdr_n;

  assign accept = byte_valid && byte_ready;
  assign hdr_n  = {cnt_hi, byte_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_HI;
      cnt_hi     <= 8'd0;
      words_left <= 16'd0;
      waddr      <= '0;
      byte_cnt   <= 2'd0;
      csum       <= 8'd0;
      shreg      <= 24'd0;
      byte_ready <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR_HI: begin
            cnt_hi <= byte_data;
            state  <= HDR_LO;
          end
          HDR_LO: begin
            words_left <= hdr_n;
            if (hdr_n == 16'd0) begin
              state <= CSUM;
            end else if ({1'b0, hdr_n} > DEPTH_V) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            // Only three bytes are kept; the fourth is merged straight into the write word.
            shreg    <= {shreg[15:0], byte_data};
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr;
              imem_wdata <= {shreg, byte_data};
              waddr      <= waddr + 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
                state <= CSUM;
              end
            end
          end
          CSUM: begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state     <= DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader: images are built from word lists and
// the expected writes, timing and final status are derived from the stream format.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with the strobe high is logged, so a widened strobe shows up as an extra write.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                wr_cyc[$];
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] img[$];
  logic [7:0]  stream[$];
  int          hs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called and returns at a falling edge; reset is asserted together with a junk byte.
  task automatic do_reset();
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok, output int hc);
    ok = 1'b0;
    hc = -1;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (byte_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        hc = cyc;
        ok = 1'b1;
        break;
      end else begin
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic load_and_check(input string tag, input int maxgap, input logic [7:0] cmask);
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    bit         ok;
    bit         good;
    int         hc;
    n = img.size();
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    foreach (img[i]) begin
      for (int j = 3; j >= 0; j--) begin
        b = img[i][8*j +: 8];
        stream.push_back(b);
        x = x ^ b;
      end
    end
    stream.push_back(x ^ cmask);
    good = (cmask == 8'h00);

    do_reset();
    clear_log();
    hs.delete();
    foreach (stream[i]) begin
      if (i == stream.size() - 1) check1({tag, ":cpu_reset_before_csum"}, cpu_reset, 1'b1);
      send_byte(stream[i], $urandom_range(0, maxgap), ok, hc);
      check1({tag, ":accepted"}, ok, 1'b1);
      hs.push_back(hc);
    end
    check1({tag, ":cpu_reset"}, cpu_reset, !good);
    check1({tag, ":load_done"}, load_done, good);
    check1({tag, ":load_error"}, load_error, !good);
    check1({tag, ":byte_ready"}, byte_ready, 1'b0);
    check({tag, ":write_count"}, 32'(wr_addr.size()), 32'(n));
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      check({tag, ":wr_addr"}, 32'(wr_addr[k]), 32'(k));
      check({tag, ":wr_data"}, wr_data[k], img[k]);
      check({tag, ":wr_cycle"}, 32'(wr_cyc[k]), 32'(hs[2 + 4*k + 3]));
    end
    repeat (3) @(negedge clk);
    send_byte(8'($urandom), 0, ok, hc);
    check1({tag, ":terminal_ignores_byte"}, ok, 1'b0);
    check1({tag, ":terminal_done"}, load_done, good);
    check1({tag, ":terminal_error"}, load_error, !good);
    check({tag, ":terminal_write_count"}, 32'(wr_addr.size()), 32'(n));
  endtask

  initial begin
    bit         ok;
    int         hc;
    int         n;
    logic [7:0] part[$];
    logic [7:0] cm;

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check1("rst:byte_ready", byte_ready, 1'b1);
    check1("rst:imem_we", imem_we, 1'b0);
    check("rst:imem_addr", 32'(imem_addr), 32'd0);
    check("rst:imem_wdata", imem_wdata, 32'd0);
    check1("rst:cpu_reset", cpu_reset, 1'b1);
    check1("rst:load_done", load_done, 1'b0);
    check1("rst:load_error", load_error, 1'b0);

    img.delete();
    img.push_back(32'h2008_0005);
    load_and_check("n1_good", 0, 8'h00);
    load_and_check("n1_bad", 0, 8'h01);

    img.delete();
    load_and_check("n0_good", 2, 8'h00);
    load_and_check("n0_bad", 0, 8'h01);

    // Header of 257 words exceeds the 256-word memory.
    do_reset();
    clear_log();
    send_byte(8'h01, 0, ok, hc);
    check1("n257:hdr_hi_accepted", ok, 1'b1);
    send_byte(8'h01, 0, ok, hc);
    check1("n257:hdr_lo_accepted", ok, 1'b1);
    check1("n257:load_error", load_error, 1'b1);
    check1("n257:load_done", load_done, 1'b0);
    check1("n257:byte_ready", byte_ready, 1'b0);
    check1("n257:cpu_reset", cpu_reset, 1'b1);
    send_byte(8'h00, 0, ok, hc);
    check1("n257:terminal_ignores_byte", ok, 1'b0);
    check("n257:write_count", 32'(wr_addr.size()), 32'd0);

    // Reset in the middle of word 1 of a two-word image.
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    do_reset();
    clear_log();
    part.delete();
    part.push_back(8'h00);
    part.push_back(8'h02);
    for (int j = 3; j >= 0; j--) part.push_back(img[0][8*j +: 8]);
    part.push_back(img[1][31:24]);
    part.push_back(img[1][23:16]);
    foreach (part[i]) begin
      send_byte(part[i], $urandom_range(0, 2), ok, hc);
      check1("midrst:accepted", ok, 1'b1);
    end
    repeat (2) @(negedge clk);
    do_reset();
    check1("midrst:imem_we", imem_we, 1'b0);
    check("midrst:imem_addr", 32'(imem_addr), 32'd0);
    check("midrst:imem_wdata", imem_wdata, 32'd0);
    check1("midrst:cpu_reset", cpu_reset, 1'b1);
    check1("midrst:byte_ready", byte_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("midrst:write_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check("midrst:wr_addr", 32'(wr_addr[0]), 32'd0);
      check("midrst:wr_data", wr_data[0], img[0]);
    end
    load_and_check("midrst_reload", 1, 8'h00);

    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    load_and_check("n3_gaps", 5, 8'h00);

    for (int r = 0; r < 6; r++) begin
      img.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img.push_back($urandom);
      cm = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      load_and_check("random", 3, cm);
    end

    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    load_and_check("full_depth", 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port byte_valid  input  1  host byte available.
REQ-005 SHALL have port byte_data  input  8  host byte.
REQ-006 SHALL have port byte_ready  output  1  loader accepts byte; transfer occurs on a clock edge with byte_valid=1 and byte_ready=1.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port imem_addr  output  ADDR_W  word address of the write.
REQ-009 SHALL have port imem_wdata  output  32  instruction word.
REQ-010 SHALL have port cpu_reset  output  1  reset driven to single_cycle; high until image verified.
REQ-011 SHALL have port load_done  output  1  image loaded and checksum matched.
REQ-012 SHALL have port load_error  output  1  image rejected.

Function
REQ-013 Stream format SHALL be: count high byte, count low byte (16-bit word count N), 4*N instruction bytes big-endian (MSB first), one checksum byte.
REQ-014 Checksum SHALL be XOR of all 4*N instruction bytes; header bytes excluded; N=0 expects 0x00.
REQ-015 FSM states SHALL be HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR; reset state HDR_HI.
REQ-016 HDR_HI -> HDR_LO on accepted byte; HDR_LO -> DATA if 1<=N<=DEPTH, -> CSUM if N=0, -> ERR if N>DEPTH.
REQ-017 DATA SHALL assemble bytes into a 32-bit shift register; on the 4th byte of word k it SHALL advance to CSUM after the last word (k=N-1), else remain in DATA.
REQ-018 imem_we SHALL be registered: high exactly one cycle, in the cycle after the 4th byte handshake of a word, with imem_addr=k and imem_wdata=assembled word; imem_addr/imem_wdata SHALL hold between strobes.
REQ-019 Word addresses SHALL start at 0 and increment by 1 per word; never wrap (bounded by REQ-016).
REQ-020 CSUM -> DONE if accepted byte equals running XOR, else -> ERR.
REQ-021 byte_ready SHALL be 1 in HDR_HI, HDR_LO, DATA, CSUM and 0 in DONE and ERR; bytes presented with byte_valid=0 SHALL be ignored; stalls of any length allowed between bytes.
REQ-022 DONE and ERR SHALL be terminal until reset.
REQ-023 cpu_reset SHALL be registered: 1 in all states except DONE; deasserts the cycle after the checksum handshake; load_done=1 and load_error=0 in DONE; load_error=1 and load_done=0 in ERR.
REQ-024 cpu_reset SHALL not deassert before the final imem_we has completed.

Reset
REQ-025 On reset=1 at a clock edge: state HDR_HI, byte_ready=1 (following cycle), imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, word counter, byte counter, checksum and shift register cleared.
REQ-026 Reset mid-load SHALL discard any partial word (no imem_we issued for it) and restart header parsing; instruction-memory contents are not cleared.
REQ-027 Reset asserted simultaneously with a byte handshake SHALL take priority; the byte SHALL be dropped.

Verification
REQ-028 N=1, bytes 00 01 20 08 00 05, checksum 2D -> one imem_we at addr 0, data 0x20080005; then load_done=1, cpu_reset=0, byte_ready=0.
REQ-029 Same image with checksum 2C -> no change to imem write count (1), load_error=1, cpu_reset stays 1, load_done=0.
REQ-030 N=0 (00 00), checksum 00 -> no imem_we, load_done=1; checksum 01 -> load_error=1.
REQ-031 ADDR_W=8, header 01 01 (N=257) -> load_error=1 the cycle after second header byte, no imem_we, byte_ready=0.
REQ-032 N=2, reset pulsed after 2 bytes of word 1 -> word 0 written at addr 0 only; reloaded full image writes addrs 0,1 and ends load_done=1.
REQ-033 N=3 with random byte_valid gaps (0-5 idle cycles) -> imem_we writes at addrs 0,1,2 in order with correct words, each strobe one cycle wide, load_done=1.
